// File: rtl/decode_execute_pipe.sv
// Decode-to-execute pipeline register with a per-register pending-write
// scoreboard that stalls issue on RAW and counter-saturation hazards.
module decode_execute_pipe #(
    parameter int registerSize = 32,
    parameter int vecSize      = 4,
    parameter int selBits      = 5,
    parameter int aluOpBits    = 4,
    parameter int cntBits      = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [selBits-1:0]               in_rSel1,
    input  logic [selBits-1:0]               in_rSel2,
    input  logic [1:0]                       in_srcEn,
    input  logic [vecSize*registerSize-1:0]  in_operand1,
    input  logic [vecSize*registerSize-1:0]  in_operand2,
    input  logic [aluOpBits-1:0]             in_aluOp,
    input  logic [selBits-1:0]               in_regToWrite,
    input  logic                             in_regWrEnSc,
    input  logic                             in_regWrEnVec,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [vecSize*registerSize-1:0]  out_operand1,
    output logic [vecSize*registerSize-1:0]  out_operand2,
    output logic [aluOpBits-1:0]             out_aluOp,
    output logic [selBits-1:0]               out_regToWrite,
    output logic                             out_regWrEnSc,
    output logic                             out_regWrEnVec,
    input  logic                             wb_en,
    input  logic [selBits-1:0]               wb_reg,
    input  logic                             wb_isVec,
    input  logic                             flush,
    output logic                             hazard_stall,
    output logic                             sb_error
);
    localparam int CW = cntBits + 1;
    localparam logic [cntBits-1:0] CMAX = '1;

    logic [cntBits-1:0] sc_cnt  [16];
    logic [cntBits-1:0] vec_cnt [4];
    logic [cntBits-1:0] sc_nxt  [16];
    logic [cntBits-1:0] vec_nxt [4];
    logic [cntBits-1:0] cnt1, cnt2;
    logic               raw, sat, hazard, accept, squash, err_nxt;
    logic               unused_wb;

    assign unused_wb = wb_reg[selBits-1];

    assign cnt1 = in_rSel1[selBits-1] ? sc_cnt[in_rSel1[3:0]]
                                      : vec_cnt[in_rSel1[1:0]];
    assign cnt2 = in_rSel2[selBits-1] ? sc_cnt[in_rSel2[3:0]]
                                      : vec_cnt[in_rSel2[1:0]];

    assign raw = (in_srcEn[0] & (|cnt1)) | (in_srcEn[1] & (|cnt2));
    assign sat = (in_regWrEnSc  & (sc_cnt[in_regToWrite[3:0]]  == CMAX))
               | (in_regWrEnVec & (vec_cnt[in_regToWrite[1:0]] == CMAX));
    assign hazard       = raw | sat;
    assign hazard_stall = in_valid & hazard;
    assign in_ready     = !hazard & !flush & (!out_valid | out_ready);
    assign accept       = in_valid & in_ready;
    assign squash       = flush & out_valid;

    // MSB of the result flags an underflow; the count then floors at zero.
    function automatic logic [CW-1:0] upd(
        input logic [cntBits-1:0] cur,
        input logic               inc,
        input logic               d0,
        input logic               d1
    );
        logic [CW-1:0] up, dn;
        up = {1'b0, cur} + CW'(inc);
        dn = CW'(d0) + CW'(d1);
        if (up < dn)
            return {1'b1, {cntBits{1'b0}}};
        return {1'b0, cntBits'(up - dn)};
    endfunction

    always_comb begin
        logic [CW-1:0] r;
        r       = '0;
        err_nxt = 1'b0;
        for (int i = 0; i < 16; i++) begin
            r = upd(sc_cnt[i],
                    accept & in_regWrEnSc & (in_regToWrite[3:0] == 4'(i)),
                    wb_en & !wb_isVec & (wb_reg[3:0] == 4'(i)),
                    squash & out_regWrEnSc & (out_regToWrite[3:0] == 4'(i)));
            sc_nxt[i] = r[cntBits-1:0];
            err_nxt   = err_nxt | r[cntBits];
        end
        for (int i = 0; i < 4; i++) begin
            r = upd(vec_cnt[i],
                    accept & in_regWrEnVec & (in_regToWrite[1:0] == 2'(i)),
                    wb_en & wb_isVec & (wb_reg[1:0] == 2'(i)),
                    squash & out_regWrEnVec & (out_regToWrite[1:0] == 2'(i)));
            vec_nxt[i] = r[cntBits-1:0];
            err_nxt    = err_nxt | r[cntBits];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_operand1   <= '0;
            out_operand2   <= '0;
            out_aluOp      <= '0;
            out_regToWrite <= '0;
            out_regWrEnSc  <= 1'b0;
            out_regWrEnVec <= 1'b0;
            sc_cnt         <= '{default: '0};
            vec_cnt        <= '{default: '0};
            sb_error       <= 1'b0;
        end else begin
            sc_cnt  <= sc_nxt;
            vec_cnt <= vec_nxt;
            if (err_nxt)
                sb_error <= 1'b1;
            if (accept) begin
                out_valid      <= 1'b1;
                out_operand1   <= in_operand1;
                out_operand2   <= in_operand2;
                out_aluOp      <= in_aluOp;
                out_regToWrite <= in_regToWrite;
                out_regWrEnSc  <= in_regWrEnSc;
                out_regWrEnVec <= in_regWrEnVec;
            end else if (flush | out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/decode_execute_pipe.md
Name: decode_execute_pipe

Overview:
- Pipeline boundary between the decode stage's register file and the SIMD execute stage.
- Captures decoded operands (scalar-broadcast or vector), ALU op and destination info into a valid/ready-handshaked register.
- Keeps a per-register pending-write scoreboard; issue is stalled on RAW and on scoreboard-saturation hazards until writeback retires the producer.
- Supports flush with correct scoreboard repair.

Parameters:
registerSize, 32, bits per lane
vecSize, 4, lanes per operand
selBits, 5, register select width; sel[4]=1 scalar file (index sel[3:0], 16 regs), sel[4]=0 vector file (index sel[1:0], 4 regs, sel[3:2] ignored)
aluOpBits, 4, ALU opcode width
cntBits, 2, per-register pending counter width (max 3 outstanding writes)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  decode presents an instruction
in_ready  out  1  instruction accepted this cycle when in_valid&in_ready
in_rSel1, in_rSel2  in  selBits  source selects, same encoding as register file
in_srcEn  in  2  bit0: rSel1 is read, bit1: rSel2 is read
in_operand1, in_operand2  in  vecSize*registerSize  operands from register file
in_aluOp  in  aluOpBits  operation
in_regToWrite  in  selBits  destination select
in_regWrEnSc, in_regWrEnVec  in  1 each  destination is scalar / vector
out_valid  out  1  execute-side instruction valid
out_ready  in  1  execute accepts when out_valid&out_ready
out_operand1, out_operand2  out  vecSize*registerSize  registered operands
out_aluOp  out  aluOpBits  registered op
out_regToWrite  out  selBits  registered destination
out_regWrEnSc, out_regWrEnVec  out  1 each  registered write enables
wb_en  in  1  writeback retires one write
wb_reg  in  selBits  retired destination
wb_isVec  in  1  1: vector file, 0: scalar file
flush  in  1  squash held instruction
hazard_stall  out  1  in_valid blocked by a hazard
sb_error  out  1  sticky: writeback to a zero counter

Behaviour:
- Reset (sync, active-high): out_valid=0; all data outputs=0; all 20 counters=0; sb_error=0.
- Hazard (combinational, registered counters only; no same-cycle writeback bypass):
  - RAW: srcEn[i] set and counter of rSel_i is non-zero.
  - Saturation: the destination counter (per write enable) equals 2^cntBits-1.
- hazard_stall = in_valid & hazard.
- in_ready = !hazard & !flush & (!out_valid | out_ready).
- Accept (in_valid&in_ready): next edge loads all out_* fields and sets out_valid=1. Latency is 1 cycle.
- No accept and out_ready&out_valid: out_valid clears next edge.
- out_* hold stable while out_valid&!out_ready.
- Scoreboard updates on accept:
  - regWrEnSc increments scalar counter [regToWrite[3:0]].
  - regWrEnVec increments vector counter [regToWrite[1:0]].
  - Both set: both increment.
- wb_en decrements the counter selected by wb_isVec/wb_reg.
  - Counter already 0: no change, sb_error sets and stays set until reset.
- Same counter incremented and decremented in one cycle: net unchanged; no sb_error if the pre-value was 0.
- Flush:
  - out_valid clears next edge; no accept that cycle.
  - If out_valid was 1, counters of the held instruction's destinations decrement (squashed write never retires).
  - That decrement combines with any same-cycle wb decrement to the same counter (net -2), floored at 0; floor hit sets sb_error.
  - flush with out_ready in the same cycle: flush wins; the instruction is not considered consumed.
- Reset mid-operation discards the held instruction and clears the scoreboard regardless of flush/wb.
- Counters wrap is impossible by construction (saturation stall).

Test Plan:
- Basic issue: reset; accept vector add (aluOp=1, dest vec 2, wrEnVec); out_ready=1 → out_valid=1 on cycle 1 with operands bit-exact; vec counter[2]=1; wb_en vec 2 → counter 0.
- RAW stall: issue write scalar 5 (sel=5'b10101); next instruction reads rSel1=5'b10101 → hazard_stall=1, in_ready=0. Assert wb scalar 5 at cycle N → in_ready=1 at N+1, not N.
- Backpressure: out_ready=0 for 3 cycles with valid held → out_* stable, in_ready=0; out_ready=1 → next queued instruction appears 1 cycle later, no loss or duplication.
- Saturation: issue 3 writes to vec 1 with no wb → 4th write to vec 1 stalls; one wb → accepted the following cycle.
- Flush repair: hold instruction writing scalar 7 (counter 1), out_ready=0, assert flush → out_valid=0, counter 0, sb_error=0. Then wb scalar 7 → sb_error=1.
- Simultaneous inc/dec: counter vec 3=1; accept write vec 3 and wb vec 3 in the same cycle → counter stays 1. Assert reset mid-stream → all counters 0, out_valid=0.
